// File: rtl/ram8_pkg.sv
// Shared constants and FSM state type for the 8-word RAM.
package ram8_pkg;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef enum logic {IDLE, CLEARING} state_t;
endpackage

// File: rtl/ram8_if.sv
// Host-side bus of ram8: write/clear requests in, read data and clear status out.
interface ram8_if;
  import ram8_pkg::*;
  logic [WIDTH-1:0] in;
  logic             load;
  logic [AW-1:0]    address;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (output in, load, address, clear, input  out, busy, done);
  modport slave  (input  in, load, address, clear, output out, busy, done);
endinterface

// File: rtl/mux8way.sv
// 8-to-1 word multiplexer used as the RAM read path.
module mux8way
  import ram8_pkg::*;
(
  input  logic [WIDTH-1:0] a, b, c, d, e, f, g, h,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end
endmodule

// File: rtl/ram8.sv
// 8x16 register RAM with combinational read and a sequential 8-cycle clear engine.
module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  ram8_if.slave  bus
);
  import ram8_pkg::*;

  state_t                       state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         busy_q, busy_d, done_q, done_d;
  logic                         wr_en, clr_en;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.clear) begin
        state_d = CLEARING;
        cnt_d   = '0;
      end
      CLEARING: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats load in IDLE; both are ignored once the sweep is running.
  always_comb begin
    clr_en = (state_q == CLEARING);
    wr_en  = (state_q == IDLE) && bus.load && !bus.clear;
    busy_d = (state_d == CLEARING);
    done_d = (state_q == CLEARING) && (cnt_q == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset)       mem_q              <= '0;
    else if (clr_en) mem_q[cnt_q]       <= '0;
    else if (wr_en)  mem_q[bus.address] <= bus.in;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  mux8way u_rd (
    .a(mem_q[0]), .b(mem_q[1]), .c(mem_q[2]), .d(mem_q[3]),
    .e(mem_q[4]), .f(mem_q[5]), .g(mem_q[6]), .h(mem_q[7]),
    .sel(bus.address),
    .out(bus.out)
  );
endmodule
